// File: rtl/gpio_ctrl_if.sv
// PicoBlaze I/O port bus between the processor (master) and a register-mapped peripheral (slave).
// Bus rule: a write is accepted on any rising edge where write_strobe=1 and port_id selects a register;
// there is no ready/stall, and in_port answers port_id one clock later.
interface gpio_ctrl_if;
  logic [7:0] port_id;
  logic       write_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;

  modport master (
    output port_id,
    output write_strobe,
    output out_port,
    input  in_port,
    input  interrupt
  );

  modport slave (
    input  port_id,
    input  write_strobe,
    input  out_port,
    output in_port,
    output interrupt
  );
endinterface

// File: rtl/gpio_ctrl.sv
// Register-mapped GPIO controller: output/enable registers, synchronised pin inputs, edge status, interrupt.
// Optional per-pin input debouncer enabled by defining GPIO_CTRL_DEBOUNCE_EN.
module gpio_ctrl #(
  parameter int         WIDTH           = 8,
  parameter logic [7:0] BASE_ADDR       = 8'h00,
  parameter int         DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  gpio_ctrl_if.slave       bus,
  output logic [WIDTH-1:0] gpio_oen,
  output logic [WIDTH-1:0] gpio_data_out,
  input  logic [WIDTH-1:0] gpio_data_in
);

  if (WIDTH < 1 || WIDTH > 8 || DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_params
    $error("gpio_ctrl: WIDTH must be 1..8 and DEBOUNCE_CYCLES 2..255");
  end

  logic [7:0]       offset;
  logic [WIDTH-1:0] wdata;
  logic             wr_dout, wr_oen, wr_stat, wr_mask, wr_sel;

  logic [WIDTH-1:0] dout_r, oen_r, stat_r, mask_r, sel_r;
  logic [WIDTH-1:0] raw, sync1, sync2, filt, prev;
  logic [WIDTH-1:0] edge_evt, stat_clr;
  logic [7:0]       rd_data, in_port_r;
  logic             irq_r;

  // Offset arithmetic wraps in 8 bits, so any BASE_ADDR works including near 8'hFF.
  assign offset  = bus.port_id - BASE_ADDR;
  assign wdata   = bus.out_port[WIDTH-1:0];
  assign wr_dout = bus.write_strobe && (offset == 8'd0);
  assign wr_oen  = bus.write_strobe && (offset == 8'd1);
  assign wr_stat = bus.write_strobe && (offset == 8'd3);
  assign wr_mask = bus.write_strobe && (offset == 8'd4);
  assign wr_sel  = bus.write_strobe && (offset == 8'd5);

  // Driven pins read back their own drive value so X/Z from the pin cell never reaches a synchroniser.
  assign raw = (oen_r & dout_r) | (~oen_r & gpio_data_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_CTRL_DEBOUNCE_EN
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  logic [7:0] db_cnt [WIDTH];

  // filt only follows sync2 after DEBOUNCE_CYCLES consecutive samples that disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] != filt[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            filt[i]   <= sync2[i];
            db_cnt[i] <= 8'd0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 8'd1;
          end
        end else begin
          db_cnt[i] <= 8'd0;
        end
      end
    end
  end
`else
  // sync2 is already the single register stage, keeping DATA_IN visible the edge sync2 updates.
  assign filt = sync2;
`endif

  assign edge_evt = (sel_r & filt & ~prev) | (~sel_r & ~filt & prev);
  assign stat_clr = wr_stat ? wdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_r <= '0;
      oen_r  <= '0;
      mask_r <= '0;
      sel_r  <= '0;
      stat_r <= '0;
      prev   <= '0;
      irq_r  <= 1'b0;
    end else begin
      if (wr_dout) dout_r <= wdata;
      if (wr_oen)  oen_r  <= wdata;
      if (wr_mask) mask_r <= wdata;
      if (wr_sel)  sel_r  <= wdata;
      // A new event outranks a simultaneous write-one-to-clear.
      stat_r <= (stat_r & ~stat_clr) | edge_evt;
      prev   <= filt;
      irq_r  <= |(stat_r & mask_r);
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (offset)
      8'd0:    rd_data[WIDTH-1:0] = dout_r;
      8'd1:    rd_data[WIDTH-1:0] = oen_r;
      8'd2:    rd_data[WIDTH-1:0] = filt;
      8'd3:    rd_data[WIDTH-1:0] = stat_r;
      8'd4:    rd_data[WIDTH-1:0] = mask_r;
      8'd5:    rd_data[WIDTH-1:0] = sel_r;
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) in_port_r <= 8'h00;
    else       in_port_r <= rd_data;
  end

  assign bus.in_port    = in_port_r;
  assign bus.interrupt  = irq_r;
  assign gpio_oen       = oen_r;
  assign gpio_data_out  = dout_r;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed timing scenarios plus randomized traffic vs a behavioural model.
// Define GPIO_CTRL_DEBOUNCE_EN for both bench and RTL to exercise the debouncer.
module tb_gpio_ctrl;
  localparam int         W    = 8;
  localparam logic [7:0] BASE = 8'h20;
`ifdef GPIO_CTRL_DEBOUNCE_EN
  localparam int DB = 16;
`else
  localparam int DB = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] gpio_oen, gpio_data_out, gpio_data_in;
  int           n_cmp = 0;
  int           n_err = 0;
  logic [7:0]   exp_q[$];

  gpio_ctrl_if bus_if ();

  gpio_ctrl #(.WIDTH(W), .BASE_ADDR(BASE), .DEBOUNCE_CYCLES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if.slave),
    .gpio_oen     (gpio_oen),
    .gpio_data_out(gpio_data_out),
    .gpio_data_in (gpio_data_in)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  logic [7:0] m_dout, m_oen, m_stat, m_mask, m_sel, m_filt, m_prev, m_in_port;
  logic       m_irq;
  logic [7:0] pipe_q[$];
  int         run_len[8];

  always @(posedge clk) begin : model
    logic [7:0] off, ev, clr, rawv, old_s2, new_filt, nxt_in;
    if (reset) begin
      m_dout = 0; m_oen = 0; m_stat = 0; m_mask = 0; m_sel = 0;
      m_filt = 0; m_prev = 0; m_in_port = 0; m_irq = 0;
      pipe_q = '{8'h00, 8'h00};
      for (int i = 0; i < 8; i++) run_len[i] = 0;
    end else begin
      off = bus_if.port_id - BASE;
      case (off)
        8'd0: nxt_in = m_dout;
        8'd1: nxt_in = m_oen;
        8'd2: nxt_in = m_filt;
        8'd3: nxt_in = m_stat;
        8'd4: nxt_in = m_mask;
        8'd5: nxt_in = m_sel;
        default: nxt_in = 8'h00;
      endcase
      for (int i = 0; i < 8; i++)
        ev[i] = m_sel[i] ? (m_filt[i] & ~m_prev[i]) : (~m_filt[i] & m_prev[i]);
      clr  = (bus_if.write_strobe && off == 8'd3) ? bus_if.out_port : 8'h00;
      rawv = (m_oen & m_dout) | (~m_oen & gpio_data_in);
      // two-stage delay line: front entry is the synchronised value
      pipe_q.push_back(rawv);
      old_s2 = pipe_q.pop_front();
      if (DB == 0) begin
        new_filt = pipe_q[0];
      end else begin
        new_filt = m_filt;
        for (int i = 0; i < 8; i++) begin
          if (old_s2[i] != m_filt[i]) begin
            run_len[i]++;
            if (run_len[i] == DB) begin
              new_filt[i] = old_s2[i];
              run_len[i]  = 0;
            end
          end else begin
            run_len[i] = 0;
          end
        end
      end
      m_irq     = |(m_stat & m_mask);
      m_stat    = (m_stat & ~clr) | ev;
      m_prev    = m_filt;
      m_filt    = new_filt;
      m_in_port = nxt_in;
      if (bus_if.write_strobe) begin
        case (off)
          8'd0: m_dout = bus_if.out_port;
          8'd1: m_oen  = bus_if.out_port;
          8'd4: m_mask = bus_if.out_port;
          8'd5: m_sel  = bus_if.out_port;
          default: ;
        endcase
      end
    end
    exp_q.push_back(m_in_port);
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus_if.port_id = a;
    bus_if.out_port = d;
    bus_if.write_strobe = 1'b1;
    @(negedge clk);
    bus_if.write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    bus_if.port_id = a;
    bus_if.write_strobe = 1'b0;
    @(negedge clk);
    v = bus_if.in_port;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] v;
    logic [7:0] addrs [7];
    for (int i = 0; i < 6; i++) addrs[i] = BASE + 8'(i);
    addrs[6] = 8'h3F;
    reset = 1'b1;
    bus_if.write_strobe = 1'b0;
    bus_if.port_id = 8'h00;
    bus_if.out_port = 8'h00;
    gpio_data_in = '0;
    step(3);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rd(addrs[i], v);
      n_cmp++;
      if (v !== 8'h00) begin
        n_err++;
        $display("FAIL reset_read[%h]: got %h expected 00", addrs[i], v);
      end
    end
    n_cmp++;
    if (bus_if.interrupt !== 1'b0) begin
      n_err++; $display("FAIL reset_irq: got %b expected 0", bus_if.interrupt);
    end
    n_cmp++;
    if (gpio_oen !== 8'h00) begin
      n_err++; $display("FAIL reset_oen: got %h expected 00", gpio_oen);
    end
    n_cmp++;
    if (gpio_data_out !== 8'h00) begin
      n_err++; $display("FAIL reset_dout: got %h expected 00", gpio_data_out);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] v;
    wr(BASE + 8'd1, 8'h0F);
    n_cmp++;
    if (gpio_oen !== 8'h0F) begin
      n_err++; $display("FAIL oen_write: got %h expected 0f", gpio_oen);
    end
    wr(BASE + 8'd0, 8'hA5);
    n_cmp++;
    if (gpio_data_out !== 8'hA5) begin
      n_err++; $display("FAIL dout_write: got %h expected a5", gpio_data_out);
    end
    gpio_data_in = 8'b0011_zzzz;
    step(3 + DB);
    rd(BASE + 8'd2, v);
    n_cmp++;
    if (v !== 8'h35) begin
      n_err++; $display("FAIL loopback_data_in: got %h expected 35", v);
    end
    wr(BASE + 8'd1, 8'h00);
    wr(BASE + 8'd0, 8'h00);
    gpio_data_in = 8'h00;
    step(4 + DB);
    wr(BASE + 8'd3, 8'hFF);
    rd(BASE + 8'd3, v);
    n_cmp++;
    if (v !== 8'h00) begin
      n_err++; $display("FAIL status_w1c_all: got %h expected 00", v);
    end
  endtask

  task automatic test_rise_irq();
    wr(BASE + 8'd5, 8'h01);
    wr(BASE + 8'd4, 8'h01);
    bus_if.port_id = BASE + 8'd3;
    gpio_data_in = 8'h01;
    step(2 + DB);
    n_cmp++;
    if (bus_if.interrupt !== 1'b0) begin
      n_err++; $display("FAIL rise_irq_k1: got %b expected 0", bus_if.interrupt);
    end
    step(1);
    n_cmp++;
    if (bus_if.interrupt !== 1'b0 || bus_if.in_port !== 8'h00) begin
      n_err++; $display("FAIL rise_k2: got irq=%b in=%h expected irq=0 in=00", bus_if.interrupt, bus_if.in_port);
    end
    step(1);
    n_cmp++;
    if (bus_if.interrupt !== 1'b1 || bus_if.in_port !== 8'h01) begin
      n_err++; $display("FAIL rise_k3: got irq=%b in=%h expected irq=1 in=01", bus_if.interrupt, bus_if.in_port);
    end
    wr(BASE + 8'd3, 8'h01);
    n_cmp++;
    if (bus_if.interrupt !== 1'b1) begin
      n_err++; $display("FAIL irq_hold_on_clear_edge: got %b expected 1", bus_if.interrupt);
    end
    step(1);
    n_cmp++;
    if (bus_if.interrupt !== 1'b0) begin
      n_err++; $display("FAIL irq_fall_after_clear: got %b expected 0", bus_if.interrupt);
    end
  endtask

  task automatic test_fall_masked();
    logic [7:0] v;
    gpio_data_in = 8'h03;
    step(4 + DB);
    wr(BASE + 8'd3, 8'hFF);
    gpio_data_in = 8'h01;
    step(4 + DB);
    rd(BASE + 8'd3, v);
    n_cmp++;
    if (v !== 8'h02 || bus_if.interrupt !== 1'b0) begin
      n_err++; $display("FAIL fall_masked: got status=%h irq=%b expected status=02 irq=0", v, bus_if.interrupt);
    end
    wr(BASE + 8'd4, 8'h02);
    n_cmp++;
    if (bus_if.interrupt !== 1'b0) begin
      n_err++; $display("FAIL unmask_edge: got %b expected 0", bus_if.interrupt);
    end
    step(1);
    n_cmp++;
    if (bus_if.interrupt !== 1'b1) begin
      n_err++; $display("FAIL unmask_rise: got %b expected 1", bus_if.interrupt);
    end
  endtask

  task automatic test_same_cycle();
    logic [7:0] v;
    gpio_data_in = 8'h00;
    step(4 + DB);
    gpio_data_in = 8'h01;
    step(2 + DB);
    wr(BASE + 8'd3, 8'h01);
    rd(BASE + 8'd3, v);
    n_cmp++;
    if (v !== 8'h03) begin
      n_err++; $display("FAIL set_beats_clear: got %h expected 03", v);
    end
  endtask

`ifdef GPIO_CTRL_DEBOUNCE_EN
  task automatic test_debounce();
    logic [7:0] v;
    wr(BASE + 8'd5, 8'h05);
    wr(BASE + 8'd3, 8'hFF);
    bus_if.port_id = BASE + 8'd2;
    gpio_data_in = 8'h05;
    step(10);
    gpio_data_in = 8'h01;
    for (int i = 0; i < 30; i++) begin
      step(1);
      n_cmp++;
      if (bus_if.in_port[2] !== 1'b0) begin
        n_err++; $display("FAIL glitch_data_in[%0d]: got %b expected 0", i, bus_if.in_port[2]);
      end
    end
    rd(BASE + 8'd3, v);
    n_cmp++;
    if (v !== 8'h00) begin
      n_err++; $display("FAIL glitch_status: got %h expected 00", v);
    end
    bus_if.port_id = BASE + 8'd2;
    gpio_data_in = 8'h05;
    step(18);
    n_cmp++;
    if (bus_if.in_port[2] !== 1'b0) begin
      n_err++; $display("FAIL debounce_early: got %b expected 0", bus_if.in_port[2]);
    end
    step(1);
    n_cmp++;
    if (bus_if.in_port[2] !== 1'b1) begin
      n_err++; $display("FAIL debounce_exact: got %b expected 1", bus_if.in_port[2]);
    end
    step(1);
    gpio_data_in = 8'h01;
    step(40);
    rd(BASE + 8'd3, v);
    n_cmp++;
    if (v !== 8'h04) begin
      n_err++; $display("FAIL debounce_status: got %h expected 04", v);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] pins, e;
    pins = gpio_data_in;
    exp_q.delete();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) pins = 8'($urandom);
      for (int i = 0; i < 8; i++) gpio_data_in[i] = m_oen[i] ? 1'bx : pins[i];
      bus_if.port_id = BASE - 8'd1 + 8'($urandom_range(0, 7));
      bus_if.write_strobe = ($urandom_range(0, 3) == 0);
      bus_if.out_port = 8'($urandom);
      step(1);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL rnd_queue[%0d]: got empty expected entry", n);
      end else begin
        e = exp_q.pop_front();
        if (bus_if.in_port !== e) begin
          n_err++; $display("FAIL rnd_in_port[%0d]: got %h expected %h", n, bus_if.in_port, e);
        end
      end
      n_cmp++;
      if (bus_if.interrupt !== m_irq || gpio_oen !== m_oen || gpio_data_out !== m_dout) begin
        n_err++;
        $display("FAIL rnd_outputs[%0d]: got irq=%b oen=%h dout=%h expected irq=%b oen=%h dout=%h",
                 n, bus_if.interrupt, gpio_oen, gpio_data_out, m_irq, m_oen, m_dout);
      end
    end
    bus_if.write_strobe = 1'b0;
  endtask

  task automatic test_reset_override();
    logic [7:0] v;
    wr(BASE + 8'd4, 8'hFF);
    reset = 1'b1;
    bus_if.write_strobe = 1'b1;
    bus_if.port_id = BASE + 8'd1;
    bus_if.out_port = 8'hFF;
    gpio_data_in = 8'hFF;
    step(1);
    reset = 1'b0;
    bus_if.write_strobe = 1'b0;
    n_cmp++;
    if (gpio_oen !== 8'h00 || gpio_data_out !== 8'h00 || bus_if.interrupt !== 1'b0) begin
      n_err++; $display("FAIL reset_override: got oen=%h dout=%h irq=%b expected 00 00 0",
                        gpio_oen, gpio_data_out, bus_if.interrupt);
    end
    rd(BASE + 8'd4, v);
    n_cmp++;
    if (v !== 8'h00) begin
      n_err++; $display("FAIL reset_mask: got %h expected 00", v);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_rise_irq();
    test_fall_masked();
    test_same_cycle();
`ifdef GPIO_CTRL_DEBOUNCE_EN
    test_debounce();
`endif
    test_random();
    test_reset_override();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
